// File: rtl/rptr_empty_level.sv
// Read-domain pointer/status block for an async FIFO: binary+Gray read pointer, write-pointer
// synchroniser, registered empty/level/almost-empty. Define RPTR_EMPTY_UNDERFLOW_EN for sticky underflow.
module rptr_empty_level #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inc,
  input  logic [ADDR_W:0]   i_writePtrAsync,
  input  logic [ADDR_W:0]   i_aeThresh,
  input  logic              i_clrErr,
  output logic [ADDR_W:0]   o_readPtr,
  output logic [ADDR_W-1:0] o_readAddr,
  output logic              o_empty,
  output logic              o_almostEmpty,
  output logic [ADDR_W:0]   o_level,
  output logic              o_underflow
);

  localparam int PW = ADDR_W + 1;

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0] sync_wptr;
  logic [PW-1:0] w_bin;

  logic [PW-1:0] counter_q;
  logic [PW-1:0] counter_next;
  logic [PW-1:0] gray_q;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] level_q;
  logic [PW-1:0] level_next;
  logic          empty_q;
  logic          empty_next;
  logic          almost_empty_q;
  logic          almost_empty_next;
  logic          pop;

  // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= i_writePtrAsync;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_wptr = sync_q[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_gray2bin
      assign w_bin[gi] = ^sync_wptr[PW-1:gi];
    end
  endgenerate

  assign pop          = i_inc && !empty_q;
  assign counter_next = counter_q + {{ADDR_W{1'b0}}, pop};
  assign gray_next    = (counter_next >> 1) ^ counter_next;

  // Status is built from the post-pop counter so a pop is reflected on the same edge.
  assign level_next        = w_bin - counter_next;
  assign empty_next        = (gray_next == sync_wptr);
  assign almost_empty_next = (level_next <= i_aeThresh);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      counter_q      <= '0;
      gray_q         <= '0;
      level_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      counter_q      <= counter_next;
      gray_q         <= gray_next;
      level_q        <= level_next;
      empty_q        <= empty_next;
      almost_empty_q <= almost_empty_next;
    end
  end

  assign o_readPtr     = gray_q;
  assign o_readAddr    = counter_q[ADDR_W-1:0];
  assign o_empty       = empty_q;
  assign o_almostEmpty = almost_empty_q;
  assign o_level       = level_q;

`ifdef RPTR_EMPTY_UNDERFLOW_EN
  logic underflow_q;

  // A new underflow takes priority over a clear arriving in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      underflow_q <= 1'b0;
    end else if (i_inc && empty_q) begin
      underflow_q <= 1'b1;
    end else if (i_clrErr) begin
      underflow_q <= 1'b0;
    end
  end

  assign o_underflow = underflow_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = i_clrErr;
  assign o_underflow    = 1'b0;
`endif

endmodule

// File: doc/rptr_empty_level.md
# rptr_empty_level

Read-domain pointer and status block for the asynchronous FIFO, the parametrised successor to the basic read-pointer/empty logic. It keeps a binary read counter and a registered Gray read pointer for the write domain. It synchronises the write domain's Gray write pointer internally and derives a registered empty flag, a fill level, and a programmable almost-empty flag. Optional underflow detection is available. It sits between the FIFO memory read port and the read-side consumer.

## Interface
- ADDR_W, 4: memory address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
- SYNC_STAGES, 2: flop stages synchronising the write pointer; legal range 2..4.
- i_clk  input  1  read-domain clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_inc  input  1  pop request; honoured only when o_empty is 0.
- i_writePtrAsync  input  ADDR_W+1  Gray write pointer from the write domain; changes at most one bit per write clock.
- i_aeThresh  input  ADDR_W+1  almost-empty threshold, in entries; treated as quasi-static.
- i_clrErr  input  1  clears sticky o_underflow.
- o_readPtr  output  ADDR_W+1  registered Gray read pointer, sent to the write domain.
- o_readAddr  output  ADDR_W  memory read address, equal to binary counter bits [ADDR_W-1:0].
- o_empty  output  1  FIFO empty, registered.
- o_almostEmpty  output  1  level <= i_aeThresh, registered.
- o_level  output  ADDR_W+1  entries available to read, registered, 0..2**ADDR_W.
- o_underflow  output  1  sticky pop-while-empty error.

## Operation
- Synchroniser: a SYNC_STAGES-deep flop chain on i_writePtrAsync produces syncWptr. Its reset value is 0. No logic sits between the stages.
- Pop: pop = i_inc && !o_empty.
  - counter_d = counter_q + pop, wrapping modulo 2**(ADDR_W+1).
  - gray_d = (counter_d >> 1) ^ counter_d.
- Pointer registers: counter_q and gray_q update on every clock. o_readPtr = gray_q and o_readAddr = counter_q[ADDR_W-1:0]; both come straight from flops, so they are glitch-free across the domain boundary.
- Status: wBin = Gray-to-binary(syncWptr); level_d = (wBin - counter_d) modulo 2**(ADDR_W+1).
  - empty_d = (gray_d == syncWptr), which is equivalent to level_d == 0.
  - almostEmpty_d = (level_d <= i_aeThresh).
  - All three are registered to o_empty, o_level and o_almostEmpty.
- Flags are pessimistic: o_level never exceeds the true occupancy, and o_empty may stay set after a write until the pointer has been synchronised.
- Pop while empty: counter, pointer and flags are unchanged. The underflow behaviour is set by the Configuration section.
- Wrap-around: the MSB of the counter distinguishes laps, so a full FIFO reports level = 2**ADDR_W and does not report empty.
- A difference greater than 2**ADDR_W is illegal upstream and is not checked.
- Reset values:
  - o_readPtr = 0, o_readAddr = 0, o_level = 0, o_underflow = 0.
  - o_empty = 1, o_almostEmpty = 1.
  - syncWptr = 0.
- Reset mid-operation: all state returns to the values above immediately and asynchronously. Pops are ignored while i_rst is high.

## Timing
- Pop to pointer: o_readAddr and o_readPtr advance on the clock edge that samples pop = 1, a latency of 1.
- Pop to flags: o_empty, o_level and o_almostEmpty reflect the pop on that same edge, because they are computed from counter_d.
- Write-pointer change to flags: a change at i_writePtrAsync, stable before edge N, is in syncWptr after edge N+SYNC_STAGES-1 and reaches the flags at edge N+SYNC_STAGES.
- Simultaneous pop and pointer arrival: level_d uses both values in the same cycle; for example, level 1 plus one new entry plus one pop gives level 1 with o_empty = 0.
- i_aeThresh change: reflected in o_almostEmpty on the next edge.

## Configuration
- RPTR_EMPTY_UNDERFLOW_EN defined:
  - i_inc = 1 while o_empty = 1 sets o_underflow on the next edge.
  - o_underflow holds until a cycle with i_clrErr = 1 clears it on the next edge.
  - If a set and a clear occur in the same cycle, the set wins.
- RPTR_EMPTY_UNDERFLOW_EN undefined:
  - o_underflow is tied to 0 and i_clrErr is ignored.
  - No underflow flop is generated.

## Test plan
All scenarios use ADDR_W = 4 and SYNC_STAGES = 2.
- Reset: assert i_rst mid-traffic -> o_empty = 1, o_almostEmpty = 1, o_level = 0, o_readPtr = 0, o_readAddr = 0, o_underflow = 0, all asynchronously.
- Fill latency: step the Gray write pointer 0 to 1 (binary 1), hold it, no pops -> o_empty falls and o_level = 1 exactly 2 edges later; with i_aeThresh = 0, o_almostEmpty falls on the same edge.
- Drain: drive the write pointer to Gray(16) = 5'b11000, then pop 16 times -> o_level goes 16, 15, ..., 0; o_empty rises on the 16th pop edge; o_readAddr wraps 15 to 0; o_readPtr ends at 5'b11000.
- Almost-empty: with i_aeThresh = 3 and level 5, pop twice -> o_almostEmpty rises on the second pop edge, when level = 3.
- Underflow, macro defined: pop while empty -> o_underflow = 1 and o_readAddr unchanged; i_clrErr plus another pop-while-empty in the same cycle -> o_underflow stays 1; i_clrErr alone -> 0.
- Underflow, macro undefined: same stimulus -> o_underflow stays 0.
- Lap wrap: run 40 writes and pops interleaved -> o_level matches the reference model every cycle, o_empty is never set while level > 0, and the pointer MSB toggles after each 16 pops.
